// File: rtl/uart_note_sched.sv
// Note-packet parser, 16-bit entry FIFO and playback sequencer for the music box.
// Bytes {0xA5, note, dur} are queued; each note sounds for dur ticks, then a one-tick gap follows.
module uart_note_sched #(
    parameter int TICK_DIV = 500000,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       play_en,
    input  logic       clear_ovf,
    output logic [7:0] note,
    output logic       note_valid,
    output logic       busy,
    output logic [4:0] fifo_count,
    output logic       overflow
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);
    localparam logic [4:0]    FULL_CNT = 5'(DEPTH);

    typedef enum logic [1:0] {P_IDLE, P_NOTE, P_DUR} pstate_e;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} sstate_e;

    pstate_e         pstate_q;
    sstate_e         state_q;
    logic [PW-1:0]   tick_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic [7:0]      note_lat_q;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [4:0]      count_q, count_d;
    logic            overflow_q;
    logic [15:0]     entry_q;
    logic [7:0]      note_q, dur_q;
    logic [PW-1:0]   play_pre_q;
    logic            note_valid_q, busy_q;
    logic            tick, push_req, push_ok, pop, full, ovf_set;

    // Free-running timebase for the parser timeout, independent of playback.
    assign tick = (tick_cnt_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick ? '0 : tick_cnt_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q   <= P_IDLE;
            to_cnt_q   <= '0;
            note_lat_q <= '0;
        end else if (rx_valid) begin
            to_cnt_q <= '0;
            case (pstate_q)
                P_IDLE:  if (rx_data == 8'hA5) pstate_q <= P_NOTE;
                P_NOTE:  begin
                    note_lat_q <= rx_data;
                    pstate_q   <= P_DUR;
                end
                default: pstate_q <= P_IDLE;
            endcase
        end else if (pstate_q == P_IDLE) begin
            to_cnt_q <= '0;
        end else if (tick) begin
            if (to_cnt_q == TO_MAX) begin
                pstate_q <= P_IDLE;
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    // A zero duration byte completes the frame but never reaches the FIFO.
    assign push_req = rx_valid && (pstate_q == P_DUR) && (rx_data != 8'h00);
    assign full     = (count_q == FULL_CNT);
    assign pop      = (state_q == S_IDLE) && play_en && (count_q != 5'd0);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; occupancy is tracked by the pointers and count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {note_lat_q, rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (ovf_set)        overflow_q <= 1'b1;
            else if (clear_ovf) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            entry_q      <= '0;
            note_q       <= '0;
            dur_q        <= '0;
            play_pre_q   <= '0;
            note_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (pop) begin
                    entry_q <= mem_q[rd_ptr_q];
                    busy_q  <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    note_q       <= entry_q[15:8];
                    dur_q        <= entry_q[7:0];
                    play_pre_q   <= '0;
                    note_valid_q <= 1'b1;
                    state_q      <= S_PLAY;
                end
                S_PLAY: begin
                    if (play_pre_q == PRE_MAX) begin
                        play_pre_q <= '0;
                        if (dur_q == 8'd1) begin
                            note_valid_q <= 1'b0;
                            state_q      <= S_GAP;
                        end else begin
                            dur_q <= dur_q - 8'd1;
                        end
                    end else begin
                        play_pre_q <= play_pre_q + PW'(1);
                    end
                end
                default: begin
                    if (play_pre_q == PRE_MAX) begin
                        play_pre_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        play_pre_q <= play_pre_q + PW'(1);
                    end
                end
            endcase
        end
    end

    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_note_sched.sv
// Directed bench for uart_note_sched: framing, timeout, FIFO overflow, playback timing and reset abort.
module tb_uart_note_sched;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;
    localparam int TIMEOUT  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       play_en = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [7:0] note;
    logic       note_valid;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    uart_note_sched #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .play_en(play_en), .clear_ovf(clear_ovf), .note(note), .note_valid(note_valid),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the edge that captured the byte.
    task automatic send_byte(input logic [7:0] b);
        step();
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_note(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (note_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit idle);
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            step();
            if (busy === 1'b0) idle = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({note, note_valid, busy, fifo_count, overflow} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0000", {note, note_valid, busy, fifo_count, overflow});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int high;
        bit low_ok;
        play_en = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h02);
        checks++;
        if (fifo_count !== 5'd1) begin failures++; $display("FAIL basic_count_push got=%0d want=1", fifo_count); end
        step();
        checks++;
        if (fifo_count !== 5'd0 || busy !== 1'b1 || note_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_load got count=%0d busy=%b nv=%b want 0 1 0", fifo_count, busy, note_valid);
        end
        step();
        checks++;
        if (note_valid !== 1'b1 || note !== 8'h3C) begin
            failures++;
            $display("FAIL basic_rise got nv=%b note=%h want 1 3c", note_valid, note);
        end
        high = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (note_valid !== 1'b1) break;
            high++;
        end
        checks++;
        if (high != 2 * TICK_DIV) begin failures++; $display("FAIL basic_high_len got=%0d want=%0d", high, 2 * TICK_DIV); end
        low_ok = 1'b1;
        for (int i = 0; i < TICK_DIV - 1; i++) begin
            step();
            if (note_valid !== 1'b0 || busy !== 1'b1) low_ok = 1'b0;
        end
        checks++;
        if (!low_ok) begin failures++; $display("FAIL basic_gap got=early_end want=%0d_gap_cycles", TICK_DIV); end
        step();
        checks++;
        if (busy !== 1'b0 || note !== 8'h3C || note_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_after got busy=%b note=%h nv=%b want 0 3c 0", busy, note, note_valid);
        end
    endtask

    task automatic test_ignore();
        bit quiet;
        play_en = 1'b1;
        send_byte(8'h11);
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h00);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (note_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL ignore_dur0 got=activity want=idle count=%0d", fifo_count); end
    endtask

    task automatic test_timeout();
        bit seen, idle;
        int high;
        play_en = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h41);
        repeat ((TIMEOUT + 2) * TICK_DIV) step();
        send_byte(8'h05);
        send_byte(8'hA5);
        send_byte(8'h42);
        send_byte(8'h01);
        step();
        checks++;
        if (fifo_count !== 5'd1) begin failures++; $display("FAIL timeout_count got=%0d want=1", fifo_count); end
        play_en = 1'b1;
        wait_note(seen);
        checks++;
        if (!seen || note !== 8'h42) begin failures++; $display("FAIL timeout_note got seen=%b note=%h want 1 42", seen, note); end
        high = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (note_valid !== 1'b1) break;
            high++;
        end
        checks++;
        if (high != TICK_DIV) begin failures++; $display("FAIL timeout_high_len got=%0d want=%0d", high, TICK_DIV); end
        wait_idle(idle);
        checks++;
        if (!idle || fifo_count !== 5'd0) begin failures++; $display("FAIL timeout_drain got idle=%b count=%0d want 1 0", idle, fifo_count); end
        play_en = 1'b0;
    endtask

    task automatic test_overflow();
        play_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'hA5);
            send_byte(8'h10 + 8'(i));
            send_byte(8'h01);
        end
        checks++;
        if (fifo_count !== 5'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full got count=%0d ovf=%b want 8 0", fifo_count, overflow);
        end
        send_byte(8'hA5);
        send_byte(8'h77);
        send_byte(8'h01);
        checks++;
        if (fifo_count !== 5'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got count=%0d ovf=%b want 8 1", fifo_count, overflow);
        end
        step();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        checks++;
        if (fifo_count !== 5'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got count=%0d ovf=%b want 8 0", fifo_count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        bit seen;
        send_byte(8'hA5);
        send_byte(8'h50);
        step();
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        play_en  = 1'b1;
        step();
        rx_valid = 1'b0;
        play_en  = 1'b0;
        checks++;
        if (fifo_count !== 5'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_full got count=%0d ovf=%b want 8 0", fifo_count, overflow);
        end
        wait_note(seen);
        checks++;
        if (!seen || note !== 8'h10) begin failures++; $display("FAIL pushpop_order got seen=%b note=%h want 1 10", seen, note); end
    endtask

    task automatic test_reset_mid_note();
        bit quiet;
        checks++;
        if (note_valid !== 1'b1) begin failures++; $display("FAIL midnote_pre got nv=%b want 1", note_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (note_valid !== 1'b0 || fifo_count !== 5'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL midnote_abort got nv=%b count=%0d busy=%b ovf=%b want 0 0 0 0", note_valid, fifo_count, busy, overflow);
        end
        step();
        rst_n   = 1'b1;
        play_en = 1'b1;
        quiet   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (note_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin failures++; $display("FAIL midnote_after got=activity want=idle"); end
        play_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_note();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
